// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, req/ack instruction-memory port, hold-until-retire handoff to decode.
// Optional FETCH_MISALIGN_CHECK_EN traps misaligned taken-branch targets into a sticky ERR state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_target
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    ERR   = 2'd3
`endif
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        taken;
  logic        retire;
  logic [31:0] target;

  always_comb begin
    taken  = branch && zero;
    retire = (state == VALID) && instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
    target = branch_target;
`else
    target = branch_target & 32'hFFFF_FFFC;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = REQ;
      REQ:   if (imem_ack) next_state = VALID;
      VALID: begin
        if (instr_ready) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (taken && (target[1:0] != 2'b00)) next_state = ERR;
          else                                  next_state = REQ;
`else
          next_state = REQ;
`endif
        end
      end
      default: next_state = state;
    endcase
  end

  // The faulting target is still loaded into pc so it is visible while in ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instruction <= NOP;
    end else begin
      if ((state == REQ) && imem_ack) instruction <= imem_rdata;
      if (retire) pc <= taken ? target : pc + 32'd4;
    end
  end

  always_comb begin
    imem_req    = (state == REQ);
    instr_valid = (state == VALID);
    imem_addr   = pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_err = (state == ERR);
`endif
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; exercises FETCH_MISALIGN_CHECK_EN paths when that macro is defined.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic [31:0] branch_target;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instruction  (instruction),
    .pc           (pc),
    .instr_ready  (instr_ready),
    .branch       (branch),
    .zero         (zero),
    .branch_target(branch_target)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic retire(input logic b, input logic z, input logic [31:0] t);
    instr_ready   = 1'b1;
    branch        = b;
    zero          = z;
    branch_target = t;
    tick();
    instr_ready   = 1'b0;
    branch        = 1'b0;
    zero          = 1'b0;
    branch_target = 32'hA5A5_A5A4;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    branch = 1'b0; zero = 1'b0; branch_target = '0;
    tick();
    tick();
    check("rst_req",   {31'd0, imem_req},    32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instruction,          32'h0000_0013);
    check("rst_pc",    pc,                   32'h0);
    check("rst_addr",  imem_addr,            32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_merr",  {31'd0, misalign_err}, 32'd0);
`endif

    // Streaming: ack and ready tied high, one instruction every 2 cycles.
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0033; instr_ready = 1'b1;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("str_req",   {31'd0, imem_req},    32'd1);
      check("str_addr",  imem_addr,            32'(4 * i));
      check("str_nv",    {31'd0, instr_valid}, 32'd0);
      tick();
      check("str_valid", {31'd0, instr_valid}, 32'd1);
      check("str_instr", instruction,          32'h0000_0033);
      check("str_pc",    pc,                   32'(4 * i));
      tick();
    end
    imem_ack = 1'b0; instr_ready = 1'b0;

    // Ack delayed three cycles: request and address held.
    for (int i = 0; i < 3; i++) begin
      check("dly_req",  {31'd0, imem_req},    32'd1);
      check("dly_addr", imem_addr,            32'h10);
      check("dly_nv",   {31'd0, instr_valid}, 32'd0);
      tick();
    end
    fetch(32'h00A0_0093);
    check("dly_valid", {31'd0, instr_valid}, 32'd1);
    check("dly_instr", instruction,          32'h00A0_0093);

    // Stall in VALID; a stray ack must not overwrite the held word.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stl_valid", {31'd0, instr_valid}, 32'd1);
      check("stl_instr", instruction,          32'h00A0_0093);
      check("stl_pc",    pc,                   32'h10);
      check("stl_req",   {31'd0, imem_req},    32'd0);
    end
    imem_ack = 1'b0;

    retire(1'b1, 1'b1, 32'h0000_0100);
    check("tkn_addr",  imem_addr,            32'h100);
    check("tkn_req",   {31'd0, imem_req},    32'd1);
    check("tkn_nv",    {31'd0, instr_valid}, 32'd0);
    fetch(32'h0000_0033);
    retire(1'b1, 1'b0, 32'h0000_0200);
    check("ntk_pc", pc, 32'h104);
    fetch(32'h0000_0033);
    retire(1'b0, 1'b1, 32'h0000_0300);
    check("ntk2_pc", pc, 32'h108);

    // Ready while fetching is ignored.
    instr_ready = 1'b1; branch = 1'b1; zero = 1'b1; branch_target = 32'h0000_0400;
    tick();
    instr_ready = 1'b0; branch = 1'b0; zero = 1'b0;
    check("rdy_ign_pc",  pc,                 32'h108);
    check("rdy_ign_req", {31'd0, imem_req},  32'd1);

    // PC+4 wraps modulo 2^32.
    fetch(32'h0000_0033);
    retire(1'b1, 1'b1, 32'hFFFF_FFFC);
    check("top_pc", pc, 32'hFFFF_FFFC);
    fetch(32'h0000_0033);
    retire(1'b0, 1'b0, 32'h0000_0040);
    check("wrap_pc",   pc,        32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset during REQ with a simultaneous ack discards the ack.
    fetch(32'h0000_0033);
    retire(1'b0, 1'b0, 32'h0);
    check("pre_rst_pc", pc, 32'h4);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    rst = 1'b0; imem_ack = 1'b0;
    check("mrst_valid", {31'd0, instr_valid}, 32'd0);
    check("mrst_req",   {31'd0, imem_req},    32'd0);
    check("mrst_pc",    pc,                   32'h0);
    check("mrst_instr", instruction,          32'h0000_0013);
    tick();
    check("mrst_req1", {31'd0, imem_req}, 32'd1);

    // Misaligned taken target.
    fetch(32'h0000_0033);
    retire(1'b1, 1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    imem_ack = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("err_flag",  {31'd0, misalign_err}, 32'd1);
      check("err_req",   {31'd0, imem_req},     32'd0);
      check("err_valid", {31'd0, instr_valid},  32'd0);
      check("err_pc",    pc,                    32'h102);
      tick();
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_clr", {31'd0, misalign_err}, 32'd0);
    check("err_pc0", pc,                    32'h0);
`else
    check("mis_pc",  pc,                 32'h100);
    check("mis_req", {31'd0, imem_req},  32'd1);
    fetch(32'h0000_0033);
    check("mis_valid", {31'd0, instr_valid}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
